// File: rtl/timer_pkg.sv
// Shared types, register map and helpers for the memory-mapped countdown timer.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned PSC_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] PRESET_OFF = 4'h4;
  localparam logic [3:0] COUNT_OFF  = 4'h8;
  localparam logic [3:0] PSC_OFF    = 4'hC;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // Replace the byte lanes of old_val selected by be with those of new_val
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit reloadable down-counter; tick_c marks the cycle where the count is zero.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [PSC_W-1:0] psc,
  output logic             tick_c
);

  logic [PSC_W-1:0] cnt_q;

  assign tick_c = (cnt_q == '0);

  // Reload on LOAD or after each tick, otherwise count down while enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= psc;
    end else if (enable) begin
      cnt_q <= tick_c ? psc : cnt_q - PSC_W'(1);
    end
  end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with interrupt request.
// Optional prescaler register at offset 0xC when TIMER_PRESCALE_EN is defined.
module timer_device
  import timer_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR    = 32'h0000_7F00,
  parameter logic [DATA_W-1:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] addr,
  input  logic [BE_W-1:0]   byteen,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   preset_q, preset_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                flag_q, flag_d;
  logic                wr_hit, wr_ctrl, wr_preset;
  logic                reload_c;
  logic                tick_c;
  logic [3:0]          reg_off;
  logic [CTRL_W-1:0]   ctrl_wr_val;
  logic                unused_addr;

  assign reg_off     = {addr[3:2], 2'b00};
  assign unused_addr = ^addr[1:0];
  assign wr_hit      = sel && (|byteen) && (addr[DATA_W-1:4] == BASE_ADDR[DATA_W-1:4]);
  assign wr_ctrl     = wr_hit && (reg_off == CTRL_OFF);
  assign wr_preset   = wr_hit && (reg_off == PRESET_OFF);
  assign ctrl_wr_val = CTRL_W'(byte_merge(DATA_W'(ctrl_q), wdata, byteen));

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q;
  logic             wr_psc;

  assign wr_psc = wr_hit && (reg_off == PSC_OFF);

  // Prescale divider register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) psc_q <= '0;
    else if (wr_psc) psc_q <= PSC_W'(byte_merge(DATA_W'(psc_q), wdata, byteen));
  end

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == LOAD),
    .enable ((state_q == CNT) && ctrl_q[CTRL_EN_BIT]),
    .psc    (psc_q),
    .tick_c (tick_c)
  );
`else
  assign tick_c = 1'b1;
`endif

  // Mode decode: reserved modes behave as one-shot
  always_comb begin
    reload_c = 1'b0;
    case (ctrl_q[CTRL_MODE_LSB +: 2])
      MODE_ONESHOT: reload_c = 1'b0;
      MODE_RELOAD:  reload_c = 1'b1;
      default:      reload_c = 1'b0;
    endcase
  end

  // Next state, counter and register updates; CPU writes override hardware updates
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: if (ctrl_q[CTRL_EN_BIT]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN_BIT]) begin
          state_d = IDLE;
        end else if (tick_c) begin
          if (count_q == '0) begin
            state_d = INT;
            flag_d  = 1'b1;
          end else begin
            count_d = count_q - DATA_W'(1);
          end
        end
      end
      INT: begin
        if (reload_c) begin
          state_d = LOAD;
          flag_d  = 1'b0;
        end else begin
          ctrl_d[CTRL_EN_BIT] = 1'b0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d = ctrl_wr_val;
      flag_d = 1'b0;
      if (state_q == INT) state_d = ctrl_wr_val[CTRL_EN_BIT] ? LOAD : IDLE;
    end
    if (wr_preset) begin
      preset_d = byte_merge(preset_q, wdata, byteen);
      flag_d   = 1'b0;
    end
  end

  // State and register flops; irq is registered from the next-state values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= RESET_PRESET;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq      <= ctrl_d[CTRL_IM_BIT] & flag_d;
    end
  end

  // Combinational register read mux
  always_comb begin
    rdata = '0;
    case (reg_off)
      CTRL_OFF:   rdata = DATA_W'(ctrl_q);
      PRESET_OFF: rdata = preset_q;
      COUNT_OFF:  rdata = count_q;
`ifdef TIMER_PRESCALE_EN
      PSC_OFF:    rdata = DATA_W'(psc_q);
`else
      PSC_OFF:    rdata = '0;
`endif
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios plus randomized bus traffic
// compared against a cycle-level behavioural model of the register/timer rules.
module tb_timer_device;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;  // 0 waiting for enable, 1 reloading, 2 counting, 3 expired
`ifdef TIMER_PRESCALE_EN
  logic [7:0]  m_psc;
  int          m_pre;
`endif

  timer_device #(.BASE_ADDR(BASE), .RESET_PRESET(32'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0: return {28'h0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
`ifdef TIMER_PRESCALE_EN
      default: return {24'h0, m_psc};
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  task automatic m_reset();
    m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_flag = 1'b0; m_phase = 0;
`ifdef TIMER_PRESCALE_EN
    m_psc = 8'h0; m_pre = 0;
`endif
  endtask

  // Advance the model by one rising edge given the bus inputs present at that edge
  task automatic m_edge(input logic s, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
    logic        hit, adv;
    logic [3:0]  c;
    logic [31:0] p, cnt;
    logic        f;
    int          ph;
    hit = s && (be != 4'h0) && (a[31:4] == BASE[31:4]);
    c = m_ctrl; p = m_preset; cnt = m_count; f = m_flag; ph = m_phase;
    case (m_phase)
      0: if (m_ctrl[0]) ph = 1;
      1: begin
        cnt = m_preset; ph = 2;
`ifdef TIMER_PRESCALE_EN
        m_pre = int'(m_psc);
`endif
      end
      2: begin
        if (!m_ctrl[0]) ph = 0;
        else begin
          adv = 1'b1;
`ifdef TIMER_PRESCALE_EN
          if (m_pre != 0) begin adv = 1'b0; m_pre--; end
          else m_pre = int'(m_psc);
`endif
          if (adv) begin
            if (m_count == 0) begin ph = 3; f = 1'b1; end
            else cnt = m_count - 1;
          end
        end
      end
      default: begin
        if (m_ctrl[2:1] == 2'b01) begin ph = 1; f = 1'b0; end
        else begin c[0] = 1'b0; ph = 0; end
      end
    endcase
    if (hit && a[3:2] == 2'd0) begin
      c = lane_merge({28'h0, m_ctrl}, wd, be) & 32'hF;
      f = 1'b0;
      if (m_phase == 3) ph = c[0] ? 1 : 0;
    end
    if (hit && a[3:2] == 2'd1) begin
      p = lane_merge(m_preset, wd, be);
      f = 1'b0;
    end
`ifdef TIMER_PRESCALE_EN
    if (hit && a[3:2] == 2'd3) m_psc = lane_merge({24'h0, m_psc}, wd, be) & 32'hFF;
`endif
    m_ctrl = c; m_preset = p; m_count = cnt; m_flag = f; m_phase = ph;
  endtask

  // Drive one bus cycle: check the read and irq before the edge, then clock model and DUT
  task automatic bus_cycle(input logic s, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
    sel = s; addr = a; byteen = be; wdata = wd;
    #1;
    check_eq("rdata", rdata, m_read(a));
    check_eq("irq", {31'h0, irq}, {31'h0, m_ctrl[3] & m_flag});
    @(posedge clk);
    m_edge(s, a, be, wd);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_cycle(1'b1, a, be, d);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic peek(input logic [31:0] a);
    sel = 1'b0; addr = a; byteen = 4'h0; wdata = 32'h0;
    #1;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; addr = 32'h0; byteen = 4'h0; wdata = 32'h0;
    m_reset();
    #1;
    peek(BASE + 32'h0); check_eq("rst_ctrl", rdata, 32'h0);
    peek(BASE + 32'h4); check_eq("rst_preset", rdata, 32'h0);
    peek(BASE + 32'h8); check_eq("rst_count", rdata, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // One-shot, PRESET=3, EN+IM
    wr(BASE + 32'h4, 32'd3, 4'hF);
    wr(BASE + 32'h0, 32'h9, 4'hF);
    idle(7, BASE + 32'h8);
    peek(BASE + 32'h0); check_eq("oneshot_ctrl", rdata, 32'h8);
    check_eq("oneshot_irq", {31'h0, irq}, 32'h1);
    peek(BASE + 32'h8); check_eq("oneshot_count", rdata, 32'h0);
    idle(3, BASE + 32'h8);

    // Auto-reload, PRESET=2
    wr(BASE + 32'h4, 32'd2, 4'hF);
    wr(BASE + 32'h0, 32'hB, 4'hF);
    idle(20, BASE + 32'h8);
    peek(BASE + 32'h0); check_eq("reload_ctrl", rdata, 32'hB);
    wr(BASE + 32'h0, 32'h0, 4'hF);
    idle(3, BASE + 32'h8);

    // Byte enables, read-only COUNT, out-of-window write
    wr(BASE + 32'h4, 32'h1122_3344, 4'hF);
    wr(BASE + 32'h4, 32'hAABB_CCDD, 4'b0100);
    peek(BASE + 32'h4); check_eq("byteen_preset", rdata, 32'h11BB_3344);
    wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    peek(BASE + 32'h8); check_eq("count_ro", rdata, m_count);
    wr(32'h0000_8004, 32'h55, 4'hF);
    peek(BASE + 32'h4); check_eq("outside_win", rdata, 32'h11BB_3344);
    wr(BASE + 32'hC, 32'h7, 4'hF);

    // Masked interrupt, then clear by CTRL write
    wr(BASE + 32'h4, 32'd1, 4'hF);
    wr(BASE + 32'h0, 32'h1, 4'hF);
    idle(6, BASE + 32'h0);
    check_eq("masked_irq", {31'h0, irq}, 32'h0);
    wr(BASE + 32'h0, 32'h8, 4'hF);
    check_eq("cleared_irq", {31'h0, irq}, 32'h0);
    idle(2, BASE + 32'h0);

    // Asynchronous reset mid-count
    wr(BASE + 32'h4, 32'd9, 4'hF);
    wr(BASE + 32'h0, 32'h9, 4'hF);
    idle(6, BASE + 32'h8);
    peek(BASE + 32'h8); check_eq("pre_rst_count", rdata, 32'd5);
    reset = 1'b1;
    #1;
    m_reset();
    peek(BASE + 32'h8); check_eq("midrst_count", rdata, 32'h0);
    peek(BASE + 32'h0); check_eq("midrst_ctrl", rdata, 32'h0);
    check_eq("midrst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(5, BASE + 32'h8);
    peek(BASE + 32'h8); check_eq("post_rst_count", rdata, 32'h0);

    // Randomized bus traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      logic [31:0] ra;
      r  = $urandom_range(0, 15);
      ra = BASE + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      if (r < 2) begin
        wr(BASE + 32'h0, $urandom, 4'($urandom_range(0, 15)));
      end else if (r == 2) begin
        wr(BASE + 32'h4, $urandom_range(0, 6),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
      end else if (r == 3) begin
        wr(BASE + (($urandom_range(0, 1) == 0) ? 32'h8 : 32'hC), $urandom_range(0, 3), 4'hF);
      end else if (r == 4) begin
        wr(32'h0000_7E00 + {28'h0, 2'($urandom_range(0, 3)), 2'b00}, $urandom, 4'hF);
      end else if (r == 5) begin
        bus_cycle(1'b0, BASE, 4'hF, $urandom);
      end else begin
        bus_cycle(1'b0, ra, 4'h0, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
